fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, pc loaded at reset.
REQ-002 SHALL have parameter FETCH_TIMEOUT, default 255, max cycles waiting in S_R before fault.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 arvalid  output  1  instruction read request valid.
REQ-006 arready  input  1  memory accepts request.
REQ-007 araddr  output  32  request address (= pc).
REQ-008 rvalid  input  1  read data valid.
REQ-009 rready  output  1  fetch accepts read data.
REQ-010 rdata  input  32  instruction word.
REQ-011 rresp  input  2  response status; nonzero = bus error.
REQ-012 inst_valid  output  1  instruction available to decode.
REQ-013 inst_ready  input  1  decode/execute consumes instruction.
REQ-014 inst  output  32  fetched instruction.
REQ-015 inst_pc  output  32  pc of inst.
REQ-016 inst_fault  output  1  fetch fault (misaligned, bus error, timeout); inst = 32'h0000_0013 (nop) when set.
REQ-017 npc_valid  input  1  commit supplies next pc.
REQ-018 npc  input  32  next pc (snpc, branch/jump target, mtvec or mepc).
REQ-019 fetch_cnt  output  32  count of completed inst transfers.

Function
REQ-020 SHALL implement FSM states S_AR, S_R, S_OUT, S_WAIT; exactly one instruction in flight.
REQ-021 S_AR: arvalid=1, araddr=pc; arvalid&arready -> S_R; arvalid and araddr SHALL hold stable until accepted.
REQ-022 S_AR with pc[1:0]!=0: no request issued (arvalid=0); capture inst_fault=1 and go to S_OUT next cycle.
REQ-023 S_R: rready=1; rvalid -> capture rdata (or nop if rresp!=0), inst_fault=(rresp!=0), -> S_OUT.
REQ-024 S_R: timeout counter increments each cycle without rvalid; reaching FETCH_TIMEOUT -> inst_fault=1, -> S_OUT; late rvalid after timeout SHALL be ignored (rready=0 outside S_R).
REQ-025 S_OUT: inst_valid=1; inst, inst_pc, inst_fault SHALL remain stable until inst_valid&inst_ready; transfer -> S_WAIT, fetch_cnt+1.
REQ-026 S_WAIT: inst_valid=0; npc_valid -> pc<=npc, -> S_AR; npc_valid outside S_WAIT SHALL be ignored.
REQ-027 npc_valid and transfer in the same cycle are impossible (different states); no extra latency required beyond: AR accept to S_R 1 cycle, rvalid to inst_valid 1 cycle, npc_valid to arvalid 1 cycle.
REQ-028 Best-case loop: arvalid&arready, rvalid next cycle, inst_ready immediately, npc_valid immediately -> 4 cycles per instruction.
REQ-029 fetch_cnt SHALL wrap modulo 2^32; timeout counter 8 bits (width from FETCH_TIMEOUT), cleared on entry to S_R.
REQ-030 rvalid while in S_AR SHALL be ignored (rready=0).

Reset
REQ-031 Asynchronous assertion: state<=S_AR, pc<=RESET_PC, inst<=32'h0000_0013, inst_pc<=RESET_PC, inst_fault<=0, fetch_cnt<=0, timeout counter<=0.
REQ-032 Outputs during reset: arvalid=0, rready=0, inst_valid=0; first arvalid SHALL assert the first posedge after rst_n deasserts.
REQ-033 Reset mid-transaction (S_R or S_OUT) SHALL abandon the instruction; a stale rvalid following release while in S_AR SHALL be ignored per REQ-030.

Structure
REQ-034 Shared package SHALL hold state encoding enum, NOP constant 32'h0000_0013, RESP_OKAY 2'b00, default RESET_PC.
REQ-035 Single module; no sub-module required, optional fetch_timer sub-module for the timeout counter.

Verification
REQ-036 Reset release, arready=1, rvalid next cycle with rdata=32'h00000297 -> inst_valid on 3rd cycle, inst=32'h00000297, inst_pc=32'h80000000, inst_fault=0.
REQ-037 arready held low 5 cycles -> arvalid=1, araddr=32'h80000000 stable all 5 cycles; no S_R entry.
REQ-038 inst_ready low 3 cycles in S_OUT -> inst/inst_pc stable; npc_valid=1, npc=32'h80000010 during that time ignored; fetch_cnt unchanged until handshake.
REQ-039 npc=32'h80000102 -> no arvalid, inst_valid next cycle with inst_fault=1, inst=32'h00000013, inst_pc=32'h80000102.
REQ-040 rresp=2'b10 -> inst_fault=1, inst=nop; no rvalid for 255 cycles -> inst_fault=1, later rvalid ignored.
REQ-041 rst_n pulsed low while in S_R -> state S_AR, pc=32'h80000000, fetch_cnt=0, inst_valid=0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_AR   = 2'd0,
    S_R    = 2'd1,
    S_OUT  = 2'd2,
    S_WAIT = 2'd3
  } fetch_state_e;

  // Instruction payload handed to decode.
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            fault;
  } inst_pkt_t;

  function automatic logic is_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_timer.sv
// Read-response wait counter; cleared when a request is accepted.
module fetch_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic         tick_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (tick_i) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: AR request, R response, hand-off to
// decode, then wait for commit to supply the next pc.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = DEFAULT_RESET_PC,
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            arvalid,
  input  logic            arready,
  output logic [XLEN-1:0] araddr,
  input  logic            rvalid,
  output logic            rready,
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      rresp,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault,
  input  logic            npc_valid,
  input  logic [XLEN-1:0] npc,
  output logic [XLEN-1:0] fetch_cnt
);

  localparam int unsigned TW = $clog2(FETCH_TIMEOUT + 1);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  inst_pkt_t       pkt_q, pkt_d;
  logic            arvalid_q, arvalid_d;
  logic            rready_q, rready_d;
  logic            inst_valid_q, inst_valid_d;
  logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
  logic            tmr_clear, tmr_tick;
  logic [TW-1:0]   tmr_count;
  logic            bus_err_c;

  assign bus_err_c = (rresp != RESP_OKAY);

  fetch_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (tmr_clear),
    .tick_i  (tmr_tick),
    .count_o (tmr_count)
  );

  // Handshake-valid flags are registered, so each is set on the edge that
  // enters its state; this keeps them low while reset is held.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pkt_d        = pkt_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    inst_valid_d = inst_valid_q;
    fetch_cnt_d  = fetch_cnt_q;
    tmr_clear    = 1'b0;
    tmr_tick     = 1'b0;
    case (state_q)
      S_AR: begin
        if (!is_aligned(pc_q)) begin
          pkt_d        = '{inst: NOP, pc: pc_q, fault: 1'b1};
          arvalid_d    = 1'b0;
          inst_valid_d = 1'b1;
          state_d      = S_OUT;
        end else if (arvalid_q && arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          tmr_clear = 1'b1;
          state_d   = S_R;
        end else begin
          arvalid_d = 1'b1;
        end
      end
      S_R: begin
        if (rvalid) begin
          pkt_d        = '{inst: bus_err_c ? NOP : rdata, pc: pc_q, fault: bus_err_c};
          rready_d     = 1'b0;
          inst_valid_d = 1'b1;
          state_d      = S_OUT;
        end else if (tmr_count == TW'(FETCH_TIMEOUT - 1)) begin
          pkt_d        = '{inst: NOP, pc: pc_q, fault: 1'b1};
          rready_d     = 1'b0;
          inst_valid_d = 1'b1;
          state_d      = S_OUT;
        end else begin
          tmr_tick = 1'b1;
        end
      end
      S_OUT: begin
        if (inst_ready) begin
          inst_valid_d = 1'b0;
          fetch_cnt_d  = fetch_cnt_q + 32'd1;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (npc_valid) begin
          pc_d      = npc;
          arvalid_d = is_aligned(npc);
          state_d   = S_AR;
        end
      end
      default: begin
        state_d = S_AR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_AR;
      pc_q         <= RESET_PC;
      pkt_q        <= '{inst: NOP, pc: RESET_PC, fault: 1'b0};
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      inst_valid_q <= 1'b0;
      fetch_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pkt_q        <= pkt_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      inst_valid_q <= inst_valid_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  assign arvalid    = arvalid_q;
  assign araddr     = pc_q;
  assign rready     = rready_q;
  assign inst_valid = inst_valid_q;
  assign inst       = pkt_q.inst;
  assign inst_pc    = pkt_q.pc;
  assign inst_fault = pkt_q.fault;
  assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized checks of fetch_unit against a transaction-level model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOPW   = 32'h0000_0013;
  localparam int unsigned TO     = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        inst_fault;
  logic        npc_valid;
  logic [31:0] npc;
  logic [31:0] fetch_cnt;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_cnt;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC), .FETCH_TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arvalid    (arvalid),
    .arready    (arready),
    .araddr     (araddr),
    .rvalid     (rvalid),
    .rready     (rready),
    .rdata      (rdata),
    .rresp      (rresp),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_fault (inst_fault),
    .npc_valid  (npc_valid),
    .npc        (npc),
    .fetch_cnt  (fetch_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold in S_OUT, hand off, then wait and supply the next pc.
  task automatic out_phase(input logic [31:0] e_inst, input logic [31:0] e_pc,
                           input logic e_fault, input int out_delay,
                           input int wait_delay, input logic [31:0] next_pc);
    for (int i = 0; i < out_delay; i++) begin
      inst_ready = 1'b0;
      npc_valid  = 1'b1;
      npc        = $urandom & 32'hFFFF_FFFC;
      step();
      check("hold_valid", 32'(inst_valid), 32'd1);
      check("hold_inst", inst, e_inst);
      check("hold_pc", inst_pc, e_pc);
      check("hold_fault", 32'(inst_fault), 32'(e_fault));
      check("hold_cnt", fetch_cnt, exp_cnt);
    end
    npc_valid  = 1'b0;
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    exp_cnt    = exp_cnt + 32'd1;
    check("xfer_valid_low", 32'(inst_valid), 32'd0);
    check("xfer_cnt", fetch_cnt, exp_cnt);
    for (int i = 0; i < wait_delay; i++) begin
      step();
      check("wait_arvalid", 32'(arvalid), 32'd0);
      check("wait_valid", 32'(inst_valid), 32'd0);
    end
    npc_valid = 1'b1;
    npc       = next_pc;
    step();
    npc_valid = 1'b0;
  endtask

  // One instruction from the S_AR entry cycle to the next S_AR entry.
  task automatic run_fetch(input logic [31:0] pc, input int ar_delay, input int r_delay,
                           input logic [1:0] resp, input logic [31:0] data, input bit tmo,
                           input int out_delay, input int wait_delay,
                           input logic [31:0] next_pc);
    logic        e_fault;
    logic [31:0] e_inst;
    e_fault = (pc[1:0] != 2'b00) || tmo || (resp != 2'b00);
    e_inst  = e_fault ? NOPW : data;
    if (pc[1:0] != 2'b00) begin
      check("mis_arvalid", 32'(arvalid), 32'd0);
      step();
      check("mis_arvalid2", 32'(arvalid), 32'd0);
    end else begin
      check("ar_valid", 32'(arvalid), 32'd1);
      check("ar_addr", araddr, pc);
      arready = 1'b0;
      rvalid  = $urandom_range(1, 0) == 1;
      rdata   = $urandom;
      for (int i = 0; i < ar_delay; i++) begin
        step();
        check("ar_hold_valid", 32'(arvalid), 32'd1);
        check("ar_hold_addr", araddr, pc);
        check("ar_rready", 32'(rready), 32'd0);
      end
      arready = 1'b1;
      step();
      arready = 1'b0;
      rvalid  = 1'b0;
      check("r_rready", 32'(rready), 32'd1);
      check("r_arvalid", 32'(arvalid), 32'd0);
      if (tmo) begin
        repeat (TO - 1) step();
        check("tmo_not_yet", 32'(inst_valid), 32'd0);
        check("tmo_rready", 32'(rready), 32'd1);
        step();
      end else begin
        repeat (r_delay) step();
        rvalid = 1'b1;
        rresp  = resp;
        rdata  = data;
        step();
        rvalid = 1'b0;
        rresp  = 2'b00;
      end
    end
    check("out_valid", 32'(inst_valid), 32'd1);
    check("out_inst", inst, e_inst);
    check("out_pc", inst_pc, pc);
    check("out_fault", 32'(inst_fault), 32'(e_fault));
    if (tmo) begin
      rvalid = 1'b1;
      rdata  = 32'hCAFE_F00D;
      check("late_rready", 32'(rready), 32'd0);
    end
    out_phase(e_inst, pc, e_fault, out_delay, wait_delay, next_pc);
    rvalid = 1'b0;
  endtask

  initial begin
    logic [31:0] cur, nxt, d;
    rst_n = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    inst_ready = 1'b0; npc_valid = 1'b0; npc = '0;
    exp_cnt = 32'd0;
    repeat (3) step();
    check("rst_arvalid", 32'(arvalid), 32'd0);
    check("rst_rready", 32'(rready), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_cnt", fetch_cnt, 32'd0);
    check("rst_inst", inst, NOPW);
    check("rst_pc", inst_pc, RST_PC);
    check("rst_fault", 32'(inst_fault), 32'd0);

    // Reset release followed by the fastest possible fetch.
    rst_n = 1'b1;
    arready = 1'b1;
    check("rel_arvalid", 32'(arvalid), 32'd0);
    step();
    check("c1_arvalid", 32'(arvalid), 32'd1);
    check("c1_araddr", araddr, RST_PC);
    step();
    arready = 1'b0;
    check("c2_rready", 32'(rready), 32'd1);
    rvalid = 1'b1; rdata = 32'h0000_0297;
    step();
    rvalid = 1'b0;
    check("c3_valid", 32'(inst_valid), 32'd1);
    check("c3_inst", inst, 32'h0000_0297);
    check("c3_pc", inst_pc, RST_PC);
    check("c3_fault", 32'(inst_fault), 32'd0);
    out_phase(32'h0000_0297, RST_PC, 1'b0, 3, 1, RST_PC);

    // Directed corner cases: AR backpressure, misaligned pc, bus error, timeout.
    run_fetch(RST_PC, 5, 0, 2'b00, 32'h1234_5678, 1'b0, 0, 0, 32'h8000_0102);
    run_fetch(32'h8000_0102, 0, 0, 2'b00, 32'h0, 1'b0, 1, 0, 32'h8000_0008);
    run_fetch(32'h8000_0008, 0, 1, 2'b10, 32'hDEAD_BEEF, 1'b0, 0, 0, 32'h8000_000C);
    run_fetch(32'h8000_000C, 1, 0, 2'b00, 32'h0, 1'b1, 2, 0, 32'h8000_0010);

    // Randomized transactions.
    cur = 32'h8000_0010;
    for (int k = 0; k < 25; k++) begin
      nxt = $urandom & 32'hFFFF_FFFC;
      if (k != 24 && $urandom_range(5, 0) == 0) nxt[1:0] = 2'($urandom_range(3, 1));
      d = $urandom;
      run_fetch(cur, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                ($urandom_range(3, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00,
                d, 1'b0, int'($urandom_range(2, 0)), int'($urandom_range(2, 0)), nxt);
      cur = nxt;
    end

    // Reset while waiting for read data abandons the fetch.
    check("pre_rst_arvalid", 32'(arvalid), 32'd1);
    arready = 1'b1;
    step();
    arready = 1'b0;
    check("pre_rst_rready", 32'(rready), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    exp_cnt = 32'd0;
    check("mid_rst_valid", 32'(inst_valid), 32'd0);
    check("mid_rst_rready", 32'(rready), 32'd0);
    check("mid_rst_cnt", fetch_cnt, 32'd0);
    check("mid_rst_addr", araddr, RST_PC);
    step();
    rst_n = 1'b1;
    rvalid = 1'b1; rdata = 32'hBAD0_BAD0;
    step();
    check("post_rst_arvalid", 32'(arvalid), 32'd1);
    check("post_rst_rready", 32'(rready), 32'd0);
    step();
    check("stale_r_valid", 32'(inst_valid), 32'd0);
    rvalid = 1'b0;
    run_fetch(RST_PC, 0, 0, 2'b00, 32'h0000_0517, 1'b0, 0, 0, 32'h8000_0004);
    check("post_rst_cnt", fetch_cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
